vliw_wb_stage: RTL

- MEM/WB pipeline register and write-back control for the two-slot VLIW core: a 32-bit slot and a 16-bit slot.
- Captures both slots' results at posedge clk and selects ALU or memory data per slot.
- Resolves destination conflicts and drives the register file's two write ports, which the register file samples at the following negedge.
- Also keeps retire and conflict statistics.

---
 rtl/vliw_wb_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vliw_wb_stage.sv
// ----------------------------------------------------------------------------
// vliw_wb_stage
//
// MEM/WB pipeline register and write-back control for the two-slot VLIW core.
// The core has a 32-bit slot and a 16-bit slot. Each slot's result is captured
// on the rising clock edge. The ALU-or-memory choice is made before the flop,
// so the WB register holds final write data. The register file samples the
// write ports on the following falling edge.
//
// Destination conflicts between the two slots are resolved here. When both
// slots write the same register, slot 32 wins and the slot-16 write is
// suppressed. Retire and conflict statistics are kept alongside.
//
// Build option:
//   VLIW_WB_PERF_CNT_EN  When defined, the retire and conflict counters are
//                        built. When undefined, no counter flops exist and
//                        both counter outputs read as zero. The conflict
//                        output and slot-16 suppression work in both builds.
//
// Ports:
//   clk              clock; all state updates on the rising edge
//   reset            asynchronous, active-low reset
//   stall            hold WB contents and suppress both writes this cycle
//   flush            load a bubble into WB (takes priority over stall)
//   valid_32_in      slot-32 instruction present
//   regWrite_32_in   slot-32 writes a register
//   memToReg_32_in   1 selects memData_32_in, 0 selects aluResult_32_in
//   rd_32_in         slot-32 destination register
//   aluResult_32_in  slot-32 ALU result
//   memData_32_in    slot-32 load data
//   *_16_in          slot-16 equivalents of the above
//   regWrite_32/16   register-file write enables
//   rd_32/16         register-file write addresses
//   writeData_32/16  register-file write data (zero when not writing)
//   conflict         both WB slots want to write the same register
//   retire_count     valid slots retired, wraps modulo 2^RET_CNT_W
//   conflict_count   conflicts seen, saturates at all-ones
// ----------------------------------------------------------------------------
module vliw_wb_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int RET_CNT_W = 32,
    parameter int CFL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,

    input  logic                 valid_32_in,
    input  logic                 regWrite_32_in,
    input  logic                 memToReg_32_in,
    input  logic [REG_AW-1:0]    rd_32_in,
    input  logic [DATA_W-1:0]    aluResult_32_in,
    input  logic [DATA_W-1:0]    memData_32_in,

    input  logic                 valid_16_in,
    input  logic                 regWrite_16_in,
    input  logic                 memToReg_16_in,
    input  logic [REG_AW-1:0]    rd_16_in,
    input  logic [DATA_W-1:0]    aluResult_16_in,
    input  logic [DATA_W-1:0]    memData_16_in,

    output logic                 regWrite_32,
    output logic [REG_AW-1:0]    rd_32,
    output logic [DATA_W-1:0]    writeData_32,

    output logic                 regWrite_16,
    output logic [REG_AW-1:0]    rd_16,
    output logic [DATA_W-1:0]    writeData_16,

    output logic                 conflict,
    output logic [RET_CNT_W-1:0] retire_count,
    output logic [CFL_CNT_W-1:0] conflict_count
);

    // WB pipeline register contents, one set per slot.
    logic              wbValid32;
    logic              wbRegWrite32;
    logic [REG_AW-1:0] wbRd32;
    logic [DATA_W-1:0] wbData32;

    logic              wbValid16;
    logic              wbRegWrite16;
    logic [REG_AW-1:0] wbRd16;
    logic [DATA_W-1:0] wbData16;

    // Write-back data is selected before the flop, so WB holds final values
    // and the output path carries no mux from the memory stage.
    logic [DATA_W-1:0] nextData32;
    logic [DATA_W-1:0] nextData16;

    assign nextData32 = memToReg_32_in ? memData_32_in : aluResult_32_in;
    assign nextData16 = memToReg_16_in ? memData_16_in : aluResult_16_in;

    // Slot-32 WB register.
    // Flush clears the qualifiers even when stalled. A bubble must never
    // become a write, whereas the rd/data fields are don't-care in a bubble.
    // Those fields take the incoming values, so no extra hold enable is
    // needed on the wide data flops during a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbValid32    <= 1'b0;
            wbRegWrite32 <= 1'b0;
            wbRd32       <= '0;
            wbData32     <= '0;
        end else if (flush) begin
            wbValid32    <= 1'b0;
            wbRegWrite32 <= 1'b0;
            wbRd32       <= rd_32_in;
            wbData32     <= nextData32;
        end else if (!stall) begin
            wbValid32    <= valid_32_in;
            wbRegWrite32 <= regWrite_32_in;
            wbRd32       <= rd_32_in;
            wbData32     <= nextData32;
        end
    end

    // Slot-16 WB register. Its behaviour matches slot 32, with one exception:
    // rd resets to 1 rather than 0. The idle slot-32 address is derived from
    // rd_16 by flipping bit 0, so this reset value makes the register-file
    // ports read rd_32=0 and rd_16=1 while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbValid16    <= 1'b0;
            wbRegWrite16 <= 1'b0;
            wbRd16       <= REG_AW'(1);
            wbData16     <= '0;
        end else if (flush) begin
            wbValid16    <= 1'b0;
            wbRegWrite16 <= 1'b0;
            wbRd16       <= rd_16_in;
            wbData16     <= nextData16;
        end else if (!stall) begin
            wbValid16    <= valid_16_in;
            wbRegWrite16 <= regWrite_16_in;
            wbRd16       <= rd_16_in;
            wbData16     <= nextData16;
        end
    end

    // Write-enable and conflict resolution.
    // Stall gates both enables. This prevents the held contents from being
    // rewritten on every stalled cycle.
    //
    // The conflict flag looks only at WB contents and ignores stall. It
    // reports what is sitting in WB. Slot 32 wins a same-register conflict,
    // so slot 16's enable is masked whenever slot 32 actually writes rd_16.
    //
    // The register file steers a register's write path to slot 32 whenever
    // rd_32 decodes to that register, even if regWrite_32 is low. An idle
    // slot 32 must therefore present an address different from rd_16, or it
    // would steal slot 16's write. Flipping bit 0 of rd_16 guarantees this.
    //
    // Write data is zeroed whenever its enable is low.
    logic sameRd;
    logic we32;
    logic we16;

    always_comb begin
        sameRd = (wbRd32 == wbRd16);
        we32   = wbValid32 & wbRegWrite32 & ~stall;
        we16   = wbValid16 & wbRegWrite16 & ~stall & ~(we32 & sameRd);

        conflict     = wbValid32 & wbRegWrite32 & wbValid16 & wbRegWrite16 & sameRd;

        regWrite_32  = we32;
        rd_32        = we32 ? wbRd32 : (wbRd16 ^ REG_AW'(1));
        writeData_32 = we32 ? wbData32 : '0;

        regWrite_16  = we16;
        rd_16        = wbRd16;
        writeData_16 = we16 ? wbData16 : '0;
    end

`ifdef VLIW_WB_PERF_CNT_EN
    // Statistics counters.
    // They advance only on unstalled edges, so an instruction held in WB
    // across a stall is counted once, when it finally leaves.
    // Retire counts valid slots regardless of regWrite. Stores and branches
    // retire too.
    // The retire counter wraps naturally. The conflict counter sticks at
    // all-ones so that software can tell it has overflowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count   <= '0;
            conflict_count <= '0;
        end else if (!stall) begin
            retire_count <= retire_count
                          + RET_CNT_W'(wbValid32)
                          + RET_CNT_W'(wbValid16);
            if (conflict && (conflict_count != {CFL_CNT_W{1'b1}})) begin
                conflict_count <= conflict_count + CFL_CNT_W'(1);
            end
        end
    end
`else
    // Counters are not built in this configuration.
    assign retire_count   = '0;
    assign conflict_count = '0;
`endif

endmodule
